uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls words from a first-word-fall-through TX FIFO and
// shifts out start, 5-8 data bits, optional parity and 1/1.5/2 stop bits on baud ticks.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] lcr,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_dout_i,
  output logic       fifo_pop_o,
  output logic       tx_o,
  output logic       sreg_empty_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [5:0] BIT_LAST    = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP15_LAST = 6'(OVERSAMPLE * 3 / 2 - 1);
  localparam logic [5:0] STOP2_LAST  = 6'(2 * OVERSAMPLE - 1);

  state_t     state_r, state_next_s;
  logic [5:0] tick_r, tick_next_s, tick_last_s;
  logic [2:0] bit_r, bit_next_s;
  logic [7:0] sreg_r, sreg_next_s;
  logic [1:0] wls_r;
  logic       stb_r, pen_r, eps_r, sticky_r, par_r;
  logic       tx_r, sreg_empty_r;
  logic       bit_end_s, load_s, level_s, tx_next_s;
  logic       unused_dlab_s;

  // Even parity over the data bits actually sent for the given word length.
  function automatic logic data_parity(input logic [7:0] d, input logic [1:0] wls);
    logic [7:0] mask;
    case (wls)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return ^(d & mask);
  endfunction

  assign unused_dlab_s = lcr[7];

  // Last tick index of the current bit period; only STOP has a configurable length.
  always_comb begin
    tick_last_s = BIT_LAST;
    if (state_r == STOP) begin
      if (!stb_r) begin
        tick_last_s = BIT_LAST;
      end else if (wls_r == 2'b00) begin
        tick_last_s = STOP15_LAST;
      end else begin
        tick_last_s = STOP2_LAST;
      end
    end else begin
      tick_last_s = BIT_LAST;
    end
  end

  assign bit_end_s = baud_pulse && (tick_r == tick_last_s);
  assign load_s    = baud_pulse && !fifo_empty_i &&
                     ((state_r == IDLE) || ((state_r == STOP) && bit_end_s));
  assign fifo_pop_o = load_s && !rst;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_next_s = state_r;
    tick_next_s  = baud_pulse ? (tick_r + 6'd1) : tick_r;
    bit_next_s   = bit_r;
    sreg_next_s  = sreg_r;
    case (state_r)
      IDLE: begin
        tick_next_s = 6'd0;
      end
      START: begin
        if (bit_end_s) begin
          state_next_s = DATA;
          tick_next_s  = 6'd0;
          bit_next_s   = 3'd0;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          tick_next_s = 6'd0;
          sreg_next_s = {1'b0, sreg_r[7:1]};
          if (bit_r == (3'd4 + {1'b0, wls_r})) begin
            state_next_s = pen_r ? PARITY : STOP;
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_next_s = STOP;
          tick_next_s  = 6'd0;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_next_s = IDLE;
          tick_next_s  = 6'd0;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
        tick_next_s  = 6'd0;
      end
    endcase
    // A load from IDLE or on the final stop tick overrides the above.
    if (load_s) begin
      state_next_s = START;
      tick_next_s  = 6'd0;
      bit_next_s   = 3'd0;
      sreg_next_s  = fifo_dout_i;
    end else begin
      bit_next_s = bit_next_s;
    end
  end

  // Line level of the state being entered; break forces the line low.
  always_comb begin
    case (state_next_s)
      IDLE:    level_s = 1'b1;
      START:   level_s = 1'b0;
      DATA:    level_s = sreg_next_s[0];
      PARITY:  level_s = sticky_r ? ~eps_r : (eps_r ? par_r : ~par_r);
      STOP:    level_s = 1'b1;
      default: level_s = 1'b1;
    endcase
    if (lcr[6]) begin
      tx_next_s = 1'b0;
    end else begin
      tx_next_s = level_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      tick_r       <= 6'd0;
      bit_r        <= 3'd0;
      sreg_r       <= 8'h00;
      wls_r        <= 2'b00;
      stb_r        <= 1'b0;
      pen_r        <= 1'b0;
      eps_r        <= 1'b0;
      sticky_r     <= 1'b0;
      par_r        <= 1'b0;
      tx_r         <= 1'b1;
      sreg_empty_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      tick_r       <= tick_next_s;
      bit_r        <= bit_next_s;
      sreg_r       <= sreg_next_s;
      tx_r         <= tx_next_s;
      sreg_empty_r <= (state_next_s == IDLE);
      if (load_s) begin
        wls_r    <= lcr[1:0];
        stb_r    <= lcr[2];
        pen_r    <= lcr[3];
        eps_r    <= lcr[4];
        sticky_r <= lcr[5];
        par_r    <= data_parity(fifo_dout_i, lcr[1:0]);
      end
    end
  end

  assign tx_o         = tx_r;
  assign sreg_empty_o = sreg_empty_r;

endmodule
